// File: rtl/ppwm_pkg.sv
// ============================================================================
// ppwm_pkg : shared types and helpers for the multi-channel programmable PWM
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package ppwm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CH   = 2'd1,
    EN   = 2'd2,
    VAL  = 2'd3
  } frame_state_e;

  // Start bit + channel index + enable bit + compare value
  function automatic int frame_len(input int idx_w, input int cnt_w);
    return 1 + idx_w + 1 + cnt_w;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ppwm_frame_rx.sv
// ============================================================================
// ppwm_frame_rx : serial frame receiver (start, index, enable, compare; MSB first)
// Rev 1.0       : initial release
// ============================================================================
`default_nettype none

module ppwm_frame_rx
  import ppwm_pkg::*;
#(
  parameter int COUNTER_WIDTH = 10,
  parameter int CH_IDX_WIDTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     data_i,
  output logic                     valid_o,
  output logic [CH_IDX_WIDTH-1:0]  idx_o,
  output logic                     en_o,
  output logic [COUNTER_WIDTH-1:0] cmp_o
);

  localparam int BIT_W = $clog2(max_int(CH_IDX_WIDTH, COUNTER_WIDTH) + 1);

  frame_state_e             state_q;
  logic [BIT_W-1:0]         bit_q;
  logic [CH_IDX_WIDTH-1:0]  idx_q;
  logic                     en_q;
  logic [COUNTER_WIDTH-1:0] cmp_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bit_q   <= '0;
      idx_q   <= '0;
      en_q    <= 1'b0;
      cmp_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (data_i) begin
            state_q <= CH;
            bit_q   <= BIT_W'(CH_IDX_WIDTH - 1);
          end
        end
        CH: begin
          idx_q <= CH_IDX_WIDTH'({idx_q, data_i});
          if (bit_q == '0) state_q <= EN;
          else             bit_q   <= bit_q - BIT_W'(1);
        end
        EN: begin
          en_q    <= data_i;
          bit_q   <= BIT_W'(COUNTER_WIDTH - 1);
          state_q <= VAL;
        end
        VAL: begin
          cmp_q <= COUNTER_WIDTH'({cmp_q, data_i});
          if (bit_q == '0) state_q <= IDLE;
          else             bit_q   <= bit_q - BIT_W'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The last compare bit is merged combinationally so the top can write its
  // shadow register on the very edge that samples that bit.
  assign valid_o = (state_q == VAL) && (bit_q == '0);
  assign idx_o   = idx_q;
  assign en_o    = en_q;
  assign cmp_o   = COUNTER_WIDTH'({cmp_q, data_i});

endmodule

`default_nettype wire

// File: rtl/ppwm_multi.sv
// ============================================================================
// ppwm_multi : NUM_CH-channel PWM with shared counter and serially programmed
//              shadow registers committed at the period boundary.
//              Define PPWM_CENTER_ALIGNED_EN for an up/down (center-aligned) counter.
// Rev 1.0    : initial release
// ============================================================================
`default_nettype none

module ppwm_multi
  import ppwm_pkg::*;
#(
  parameter  int NUM_CH        = 4,
  parameter  int COUNTER_WIDTH = 10,
  localparam int CH_IDX_WIDTH  = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              data_i,
  output logic [NUM_CH-1:0] pwm_o,
  output logic              period_start_o,
  output logic              frame_done_o,
  output logic              frame_err_o
);

  typedef struct packed {
    logic                     en;
    logic [COUNTER_WIDTH-1:0] cmp;
  } ch_cfg_t;

  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;

  logic                     rx_valid;
  logic [CH_IDX_WIDTH-1:0]  rx_idx;
  logic                     rx_en;
  logic [COUNTER_WIDTH-1:0] rx_cmp;
  logic                     idx_ok;

  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
  logic                     commit;
  ch_cfg_t                  act_q [NUM_CH];
  ch_cfg_t                  shd_q [NUM_CH];
  logic [NUM_CH-1:0]        pend_q;
  logic                     done_q, err_q;

  ppwm_frame_rx #(
    .COUNTER_WIDTH (COUNTER_WIDTH),
    .CH_IDX_WIDTH  (CH_IDX_WIDTH)
  ) u_rx (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_i  (data_i),
    .valid_o (rx_valid),
    .idx_o   (rx_idx),
    .en_o    (rx_en),
    .cmp_o   (rx_cmp)
  );

  assign idx_ok = ({1'b0, rx_idx} < (CH_IDX_WIDTH + 1)'(NUM_CH));

`ifdef PPWM_CENTER_ALIGNED_EN
  logic dir_q, dir_d;

  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (!dir_q) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d = cnt_q - COUNTER_WIDTH'(1);
        dir_d = 1'b1;
      end else begin
        cnt_d = cnt_q + COUNTER_WIDTH'(1);
      end
    end else begin
      if (cnt_q == '0) begin
        cnt_d = cnt_q + COUNTER_WIDTH'(1);
        dir_d = 1'b0;
      end else begin
        cnt_d = cnt_q - COUNTER_WIDTH'(1);
      end
    end
  end

  // Commit only on the downward step into zero (bottom of the triangle)
  assign commit = dir_q && (cnt_q == COUNTER_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) dir_q <= 1'b0;
    else        dir_q <= dir_d;
  end
`else
  assign cnt_d  = cnt_q + COUNTER_WIDTH'(1);
  assign commit = (cnt_q == CNT_MAX);
`endif

  // A write landing on the commit edge re-arms pending after the commit clears it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      pend_q <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        act_q[i] <= '0;
        shd_q[i] <= '0;
      end
    end else begin
      cnt_q  <= cnt_d;
      done_q <= rx_valid && idx_ok;
      err_q  <= rx_valid && !idx_ok;
      for (int i = 0; i < NUM_CH; i++) begin
        if (commit && pend_q[i]) begin
          act_q[i]  <= shd_q[i];
          pend_q[i] <= 1'b0;
        end
        if (rx_valid && idx_ok && (rx_idx == CH_IDX_WIDTH'(i))) begin
          shd_q[i]  <= {rx_en, rx_cmp};
          pend_q[i] <= 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pwm
    assign pwm_o[g] = act_q[g].en && (cnt_q < act_q[g].cmp);
  end

  assign period_start_o = (cnt_q == '0);
  assign frame_done_o   = done_q;
  assign frame_err_o    = err_q;

endmodule

`default_nettype wire

// File: tb/tb_ppwm_multi.sv
// ============================================================================
// tb_ppwm_multi : self-checking bench for ppwm_multi (NUM_CH=3, W=4)
// Rev 1.0       : initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ppwm_multi;

  localparam int NCH = 3;
  localparam int W   = 4;
  localparam int IW  = 2;
  localparam int FL  = ppwm_pkg::frame_len(IW, W);
  localparam int MAXV = (1 << W) - 1;
`ifdef PPWM_CENTER_ALIGNED_EN
  localparam int P = 2 * MAXV;
`else
  localparam int P = 1 << W;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           data_i = 1'b0;
  logic [NCH-1:0] pwm_o;
  logic           period_start_o;
  logic           frame_done_o;
  logic           frame_err_o;

  ppwm_multi #(.NUM_CH(NCH), .COUNTER_WIDTH(W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_i         (data_i),
    .pwm_o          (pwm_o),
    .period_start_o (period_start_o),
    .frame_done_o   (frame_done_o),
    .frame_err_o    (frame_err_o)
  );

  always #5 clk = ~clk;

  // Reference model: every accepted write with the cycle index it became
  // visible at; a write takes effect at the first period start after it.
  typedef struct {
    int ch;
    bit en;
    int cmp;
    int e;
  } wr_t;

  wr_t wq[$];
  int  k;
  int  total = 0;
  int  bad   = 0;

  function automatic int cnt_at(input int t);
    int p;
    p = t % P;
`ifdef PPWM_CENTER_ALIGNED_EN
    return (p <= MAXV) ? p : P - p;
`else
    return p;
`endif
  endfunction

  function automatic logic [NCH-1:0] exp_pwm(input int t);
    logic [NCH-1:0] r;
    int best;
    bit en;
    int cmp;
    r = '0;
    for (int c = 0; c < NCH; c++) begin
      best = -1; en = 1'b0; cmp = 0;
      foreach (wq[j]) begin
        if (wq[j].ch == c && ((wq[j].e / P) + 1) * P <= t && wq[j].e > best) begin
          best = wq[j].e; en = wq[j].en; cmp = wq[j].cmp;
        end
      end
      r[c] = en && (cnt_at(t) < cmp);
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic send_frame(input int ch, input bit en, input int cmp);
    logic [FL-1:0] f;
    wr_t w;
    f = {1'b1, IW'(ch), en, W'(cmp)};
    for (int i = FL - 1; i >= 0; i--) begin
      data_i = f[i];
      tick();
    end
    data_i = 1'b0;
    if (ch < NCH) begin
      w.ch = ch; w.en = en; w.cmp = cmp; w.e = k;
      wq.push_back(w);
    end
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    data_i = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    wq.delete();
    k = 0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (pwm_o !== '0 || frame_done_o !== 1'b0 || frame_err_o !== 1'b0 || period_start_o !== 1'b1) begin
      bad++;
      $display("FAIL reset_state pwm=%b done=%b err=%b ps=%b required pwm=000 done=0 err=0 ps=1",
               pwm_o, frame_done_o, frame_err_o, period_start_o);
    end
    for (int n = 0; n < 32; n++) begin
      tick();
      total++;
      if (pwm_o !== '0 || period_start_o !== (cnt_at(k) == 0)) begin
        bad++;
        $display("FAIL reset_idle k=%0d pwm=%b ps=%b required pwm=000 ps=%b",
                 k, pwm_o, period_start_o, cnt_at(k) == 0);
      end
    end
  endtask

  task automatic test_single();
    for (int n = 0; n < P && cnt_at(k) != 3; n++) tick();
    send_frame(2, 1'b1, 5);
    total++;
    if (frame_done_o !== 1'b1 || frame_err_o !== 1'b0) begin
      bad++;
      $display("FAIL single_done done=%b err=%b required done=1 err=0", frame_done_o, frame_err_o);
    end
    for (int n = 0; n < 2 * P + 4; n++) begin
      tick();
      total++;
      if (pwm_o !== exp_pwm(k) || frame_done_o !== 1'b0 || period_start_o !== (cnt_at(k) == 0)) begin
        bad++;
        $display("FAIL single_pwm k=%0d pwm=%b done=%b ps=%b required pwm=%b done=0 ps=%b",
                 k, pwm_o, frame_done_o, period_start_o, exp_pwm(k), cnt_at(k) == 0);
      end
    end
  endtask

  task automatic test_err();
    for (int n = 0; n < P && cnt_at(k) != 2; n++) tick();
    send_frame(3, 1'b1, 9);
    total++;
    if (frame_err_o !== 1'b1 || frame_done_o !== 1'b0) begin
      bad++;
      $display("FAIL err_pulse err=%b done=%b required err=1 done=0", frame_err_o, frame_done_o);
    end
    for (int n = 0; n < P + 4; n++) begin
      tick();
      total++;
      if (pwm_o !== exp_pwm(k) || frame_err_o !== 1'b0) begin
        bad++;
        $display("FAIL err_pwm k=%0d pwm=%b err=%b required pwm=%b err=0", k, pwm_o, frame_err_o, exp_pwm(k));
      end
    end
  endtask

  task automatic test_wrap_edge();
    for (int n = 0; n < P && ((k + FL) % P) != 0; n++) tick();
    send_frame(1, 1'b1, 10);
    total++;
    if (frame_done_o !== 1'b1 || cnt_at(k) != 0) begin
      bad++;
      $display("FAIL wrap_done done=%b k=%0d required done=1 at period start", frame_done_o, k);
    end
    for (int n = 0; n < 2 * P; n++) begin
      tick();
      total++;
      if (pwm_o !== exp_pwm(k)) begin
        bad++;
        $display("FAIL wrap_pwm k=%0d pwm=%b required %b", k, pwm_o, exp_pwm(k));
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < P && (k % P) != P - 1; n++) tick();
    send_frame(0, 1'b1, 3);
    total++;
    if (frame_done_o !== 1'b1) begin
      bad++;
      $display("FAIL b2b_done1 done=%b required 1", frame_done_o);
    end
    send_frame(0, 1'b1, 9);
    total++;
    if (frame_done_o !== 1'b1) begin
      bad++;
      $display("FAIL b2b_done2 done=%b required 1", frame_done_o);
    end
    for (int n = 0; n < 2 * P; n++) begin
      tick();
      total++;
      if (pwm_o !== exp_pwm(k)) begin
        bad++;
        $display("FAIL b2b_pwm k=%0d pwm=%b required %b", k, pwm_o, exp_pwm(k));
      end
    end
  endtask

  task automatic test_midreset();
    logic [FL-1:0] f;
    for (int n = 0; n < P && cnt_at(k) != 4; n++) tick();
    f = {1'b1, 2'd2, 1'b1, 4'd15};
    for (int i = FL - 1; i >= 2; i--) begin
      data_i = f[i];
      tick();
    end
    do_reset();
    total++;
    if (pwm_o !== '0 || frame_done_o !== 1'b0 || frame_err_o !== 1'b0) begin
      bad++;
      $display("FAIL midreset_state pwm=%b done=%b err=%b required 000/0/0", pwm_o, frame_done_o, frame_err_o);
    end
    send_frame(1, 1'b1, 7);
    total++;
    if (frame_done_o !== 1'b1) begin
      bad++;
      $display("FAIL midreset_done done=%b required 1", frame_done_o);
    end
    for (int n = 0; n < 2 * P; n++) begin
      tick();
      total++;
      if (pwm_o !== exp_pwm(k)) begin
        bad++;
        $display("FAIL midreset_pwm k=%0d pwm=%b required %b", k, pwm_o, exp_pwm(k));
      end
    end
  endtask

  task automatic test_boundary();
    send_frame(0, 1'b1, 0);
    send_frame(1, 1'b1, MAXV);
    send_frame(2, 1'b0, 8);
    for (int n = 0; n < 2 * P + 2; n++) begin
      tick();
      total++;
      if (pwm_o !== exp_pwm(k)) begin
        bad++;
        $display("FAIL boundary_pwm k=%0d cnt=%0d pwm=%b required %b", k, cnt_at(k), pwm_o, exp_pwm(k));
      end
    end
  endtask

  task automatic test_random();
    int gap, ch, cmp;
    bit en;
    for (int it = 0; it < 14; it++) begin
      gap = $urandom_range(0, P);
      for (int n = 0; n < gap; n++) begin
        tick();
        total++;
        if (pwm_o !== exp_pwm(k) || frame_done_o !== 1'b0 || frame_err_o !== 1'b0) begin
          bad++;
          $display("FAIL rand_gap k=%0d pwm=%b done=%b err=%b required pwm=%b done=0 err=0",
                   k, pwm_o, frame_done_o, frame_err_o, exp_pwm(k));
        end
      end
      ch  = $urandom_range(0, 3);
      en  = 1'($urandom_range(0, 1));
      cmp = $urandom_range(0, MAXV);
      send_frame(ch, en, cmp);
      total++;
      if (frame_done_o !== (ch < NCH) || frame_err_o !== (ch >= NCH)) begin
        bad++;
        $display("FAIL rand_frame ch=%0d done=%b err=%b required done=%b err=%b",
                 ch, frame_done_o, frame_err_o, ch < NCH, ch >= NCH);
      end
    end
    for (int n = 0; n < 2 * P + 2; n++) begin
      tick();
      total++;
      if (pwm_o !== exp_pwm(k) || period_start_o !== (cnt_at(k) == 0)) begin
        bad++;
        $display("FAIL rand_tail k=%0d pwm=%b ps=%b required pwm=%b ps=%b",
                 k, pwm_o, period_start_o, exp_pwm(k), cnt_at(k) == 0);
      end
    end
  endtask

  initial begin
    k = 0;
    test_reset();
    test_single();
    test_err();
    test_wrap_edge();
    test_back_to_back();
    test_midreset();
    test_boundary();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
